// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma rotor datapath.
package enigma_pkg;

    localparam int NUM_LETTERS    = 26;
    localparam int W              = 5;
    localparam int NOTCH0_DEFAULT = 16;
    localparam int NOTCH1_DEFAULT = 4;

    typedef logic [W-1:0] letter_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/mod26_counter.sv
// Single rotor position register: loadable, increments with mod-NUM_LETTERS wrap.
module mod26_counter
    import enigma_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] LAST = W'(NUM_LETTERS - 1);

    // Reset to position 0, otherwise load or step with wrap from the last letter back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= (q == LAST) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/rotor_position_stepper.sv
// Keypress front end: accepts a letter, steps three rotors Enigma-style (including
// the middle-rotor double step), then holds letter and positions until consumed.
module rotor_position_stepper
    import enigma_pkg::*;
#(
    parameter int NOTCH0 = NOTCH0_DEFAULT,
    parameter int NOTCH1 = NOTCH1_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_pos0,
    input  logic [W-1:0] load_pos1,
    input  logic [W-1:0] load_pos2,
    output logic         load_err,
    input  logic         key_valid,
    input  logic [W-1:0] key_in,
    output logic         key_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] letter_out,
    output logic [W-1:0] pos0,
    output logic [W-1:0] pos1,
    output logic [W-1:0] pos2
);

    localparam logic [W-1:0] LIMIT    = W'(NUM_LETTERS);
    localparam logic [W-1:0] NOTCH0_V = W'(NOTCH0);
    localparam logic [W-1:0] NOTCH1_V = W'(NOTCH1);

    state_t state;
    logic   in_idle;
    logic   in_step;
    logic   load_ok;
    logic   do_load;
    logic   at_notch0;
    logic   at_notch1;
    logic   inc0;
    logic   inc1;
    logic   inc2;

    assign in_idle   = (state == IDLE);
    assign in_step   = (state == STEP);
    assign load_ok   = (load_pos0 < LIMIT) && (load_pos1 < LIMIT) && (load_pos2 < LIMIT);
    assign do_load   = in_idle && load && load_ok;

    // Notch compares use the pre-step positions; rotor 1 steps once even when both notches hit.
    assign at_notch0 = (pos0 == NOTCH0_V);
    assign at_notch1 = (pos1 == NOTCH1_V);
    assign inc0      = in_step;
    assign inc1      = in_step && (at_notch0 || at_notch1);
    assign inc2      = in_step && at_notch1;

    assign key_ready = in_idle;
    assign out_valid = (state == OUT);

    // Sequencer: load has priority over a key in IDLE; OUT waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!load && key_valid) state <= STEP;
                STEP:    state <= OUT;
                OUT:     if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Captured letter only changes when a key is accepted, so it stays stable through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            letter_out <= '0;
        end else if (in_idle && !load && key_valid) begin
            letter_out <= key_in;
        end
    end

    // Out-of-range load request raises a single-cycle error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= in_idle && load && !load_ok;
        end
    end

    mod26_counter u_rotor0 (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .load_val (load_pos0),
        .inc      (inc0),
        .q        (pos0)
    );

    mod26_counter u_rotor1 (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .load_val (load_pos1),
        .inc      (inc1),
        .q        (pos1)
    );

    mod26_counter u_rotor2 (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .load_val (load_pos2),
        .inc      (inc2),
        .q        (pos2)
    );

endmodule

// File: tb/tb_rotor_position_stepper.sv
// Directed self-checking bench for rotor_position_stepper.
module tb_rotor_position_stepper;

    logic       clk;
    logic       rst;
    logic       load;
    logic [4:0] load_pos0;
    logic [4:0] load_pos1;
    logic [4:0] load_pos2;
    logic       load_err;
    logic       key_valid;
    logic [4:0] key_in;
    logic       key_ready;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] letter_out;
    logic [4:0] pos0;
    logic [4:0] pos1;
    logic [4:0] pos2;

    int tests_run;
    int tests_failed;

    rotor_position_stepper dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_pos0  (load_pos0),
        .load_pos1  (load_pos1),
        .load_pos2  (load_pos2),
        .load_err   (load_err),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .letter_out (letter_out),
        .pos0       (pos0),
        .pos1       (pos1),
        .pos2       (pos2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one load request for a single cycle.
    task automatic do_load(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
        load = 1'b1; load_pos0 = p0; load_pos1 = p1; load_pos2 = p2;
        tick();
        load = 1'b0;
    endtask

    // Offer one key, then wait (bounded) for out_valid; lat counts edges after the accept edge, -1 on timeout.
    task automatic send_key(input logic [4:0] k, output int lat);
        key_in = k; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    // Consume the presented output with a one-cycle out_ready pulse.
    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({pos2, pos1, pos0} !== 15'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pos got %0d/%0d/%0d want 0/0/0", pos0, pos1, pos2);
        end
        tests_run++;
        if ({out_valid, key_ready, load_err} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags got out_valid=%b key_ready=%b load_err=%b want 0 1 0",
                     out_valid, key_ready, load_err);
        end
    endtask

    task automatic test_first_key();
        int lat;
        out_ready = 1'b1;
        send_key(5'd0, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("[TB] FAIL first_latency got %0d want 1", lat);
        end
        tests_run++;
        if (letter_out !== 5'd0 || {pos2, pos1, pos0} !== {5'd0, 5'd0, 5'd1}) begin
            tests_failed++;
            $display("[TB] FAIL first_out got L=%0d %0d/%0d/%0d want L=0 1/0/0",
                     letter_out, pos0, pos1, pos2);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_return got out_valid=%b key_ready=%b want 0 1", out_valid, key_ready);
        end
    endtask

    task automatic test_notch0();
        int lat;
        do_load(5'd16, 5'd0, 5'd0);
        send_key(5'd7, lat);
        tests_run++;
        if (lat !== 1 || letter_out !== 5'd7 || {pos2, pos1, pos0} !== {5'd0, 5'd1, 5'd17}) begin
            tests_failed++;
            $display("[TB] FAIL notch0_hit got lat=%0d L=%0d %0d/%0d/%0d want lat=1 L=7 17/1/0",
                     lat, letter_out, pos0, pos1, pos2);
        end
        release_out();
        do_load(5'd15, 5'd0, 5'd0);
        send_key(5'd12, lat);
        tests_run++;
        if (lat !== 1 || {pos2, pos1, pos0} !== {5'd0, 5'd0, 5'd16}) begin
            tests_failed++;
            $display("[TB] FAIL notch0_miss got lat=%0d %0d/%0d/%0d want lat=1 16/0/0",
                     lat, pos0, pos1, pos2);
        end
        release_out();
    endtask

    task automatic test_double_step();
        int lat;
        do_load(5'd16, 5'd3, 5'd0);
        send_key(5'd1, lat);
        tests_run++;
        if (lat !== 1 || {pos2, pos1, pos0} !== {5'd0, 5'd4, 5'd17}) begin
            tests_failed++;
            $display("[TB] FAIL dbl_first got lat=%0d %0d/%0d/%0d want lat=1 17/4/0",
                     lat, pos0, pos1, pos2);
        end
        release_out();
        send_key(5'd2, lat);
        tests_run++;
        if (lat !== 1 || {pos2, pos1, pos0} !== {5'd1, 5'd5, 5'd18}) begin
            tests_failed++;
            $display("[TB] FAIL dbl_second got lat=%0d %0d/%0d/%0d want lat=1 18/5/1",
                     lat, pos0, pos1, pos2);
        end
        release_out();
        do_load(5'd16, 5'd4, 5'd7);
        send_key(5'd3, lat);
        tests_run++;
        if (lat !== 1 || {pos2, pos1, pos0} !== {5'd8, 5'd5, 5'd17}) begin
            tests_failed++;
            $display("[TB] FAIL dbl_both got lat=%0d %0d/%0d/%0d want lat=1 17/5/8",
                     lat, pos0, pos1, pos2);
        end
        release_out();
    endtask

    task automatic test_wrap_backpressure();
        int lat;
        do_load(5'd25, 5'd25, 5'd25);
        send_key(5'd9, lat);
        tests_run++;
        if (lat !== 1 || {pos2, pos1, pos0} !== {5'd25, 5'd25, 5'd0}) begin
            tests_failed++;
            $display("[TB] FAIL wrap got lat=%0d %0d/%0d/%0d want lat=1 0/25/25",
                     lat, pos0, pos1, pos2);
        end
        // Stall the consumer while a second key and a load try to get in.
        key_valid = 1'b1; key_in = 5'd3;
        load_pos0 = 5'd1; load_pos1 = 5'd1; load_pos2 = 5'd1; load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || key_ready !== 1'b0 || load_err !== 1'b0 || letter_out !== 5'd9 ||
                {pos2, pos1, pos0} !== {5'd25, 5'd25, 5'd0}) begin
                tests_failed++;
                $display("[TB] FAIL stall_%0d got ov=%b kr=%b le=%b L=%0d %0d/%0d/%0d want 1 0 0 L=9 0/25/25",
                         i, out_valid, key_ready, load_err, letter_out, pos0, pos1, pos2);
            end
        end
        key_valid = 1'b0; load = 1'b0;
        release_out();
        tests_run++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1 || letter_out !== 5'd9) begin
            tests_failed++;
            $display("[TB] FAIL stall_release got ov=%b kr=%b L=%0d want 0 1 L=9",
                     out_valid, key_ready, letter_out);
        end
        tick();
        tests_run++;
        if (key_ready !== 1'b1 || {pos2, pos1, pos0} !== {5'd25, 5'd25, 5'd0}) begin
            tests_failed++;
            $display("[TB] FAIL stall_not_queued got kr=%b %0d/%0d/%0d want 1 0/25/25",
                     key_ready, pos0, pos1, pos2);
        end
    endtask

    task automatic test_errors_reset();
        int lat;
        do_load(5'd1, 5'd2, 5'd3);
        do_load(5'd27, 5'd0, 5'd0);
        tests_run++;
        if (load_err !== 1'b1 || {pos2, pos1, pos0} !== {5'd3, 5'd2, 5'd1}) begin
            tests_failed++;
            $display("[TB] FAIL load_err_pulse got le=%b %0d/%0d/%0d want 1 1/2/3",
                     load_err, pos0, pos1, pos2);
        end
        tick();
        tests_run++;
        if (load_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_err_width got %b want 0", load_err);
        end
        do_load(5'd0, 5'd0, 5'd26);
        tests_run++;
        if (load_err !== 1'b1 || {pos2, pos1, pos0} !== {5'd3, 5'd2, 5'd1}) begin
            tests_failed++;
            $display("[TB] FAIL load_err_pos2 got le=%b %0d/%0d/%0d want 1 1/2/3",
                     load_err, pos0, pos1, pos2);
        end
        send_key(5'd20, lat);
        tests_run++;
        if (lat !== 1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset got lat=%0d ov=%b want 1 1", lat, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1 || letter_out !== 5'd0 ||
            {pos2, pos1, pos0} !== 15'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_out got ov=%b kr=%b L=%0d %0d/%0d/%0d want 0 1 L=0 0/0/0",
                     out_valid, key_ready, letter_out, pos0, pos1, pos2);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b0; load = 1'b0; key_valid = 1'b0; out_ready = 1'b0;
        key_in = '0; load_pos0 = '0; load_pos1 = '0; load_pos2 = '0;
        @(negedge clk);
        test_reset();
        test_first_key();
        test_notch0();
        test_double_step();
        test_wrap_backpressure();
        test_errors_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
